// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- writeback stage, sole driver of the register file write port.
//
// Merges single-cycle ALU results with variable-latency load returns.
// Load data is byte-lane extracted and sign/zero extended here. The stage also
// keeps a pending-load scoreboard (busy) that decode uses for load-use stalls.
//
// A load return cannot be back-pressured, so it always wins the write port.
// An ALU result that collides with a load return is parked in a one-entry hold
// buffer. alu_ready is low while that buffer is occupied.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   alu_valid/ready    ALU result handshake; alu_rd, alu_data carry the payload
//   ld_issue/_rd       a load was issued to memory; marks ld_issue_rd busy
//   ld_valid           load data returning; ld_rd, ld_funct3, ld_offset,
//                      ld_rdata describe it
//   wb_en/wb_rd/wb_data registered regfile write port
//   busy[NREG]         bit i set = load outstanding to x[i]
//   ld_err             one-cycle pulse for a bad or unexpected load return
//
// Optional feature (macro WB_FWD_EN): adds the fwd_rs1/fwd_rs2 inputs and the
// fwd_hit[1:0]/fwd_data outputs. These let decode bypass the regfile's
// read-during-write old value.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module wb_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_rd,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_offset,
  input  logic [XLEN-1:0] ld_rdata,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [NREG-1:0] busy,
  output logic            ld_err
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]      fwd_rs1,
  input  logic [4:0]      fwd_rs2,
  output logic [1:0]      fwd_hit,
  output logic [XLEN-1:0] fwd_data
`endif
);

  localparam logic [0:0] HOLD_EMPTY = 1'b0;
  localparam logic [0:0] HOLD_FULL  = 1'b1;

  logic [0:0]      hold_state;
  logic [4:0]      hold_rd;
  logic [XLEN-1:0] hold_data;

  logic            alu_xfer;
  logic [XLEN-1:0] ld_shifted;
  logic [XLEN-1:0] ld_ext;
  logic            ld_bad;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic            ld_was_busy;

  assign alu_ready = (hold_state == HOLD_EMPTY);
  assign alu_xfer  = alu_valid && alu_ready;

  // Move the addressed byte/halfword down to bit 0. ld_bad flags encodings
  // that are not loads and accesses that are misaligned for their size.
  always_comb begin
    ld_shifted = ld_rdata >> {ld_offset, 3'b000};
    ld_ext     = '0;
    ld_bad     = 1'b0;
    case (ld_funct3)
      3'b000: ld_ext = {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001: begin
        ld_ext = {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
        ld_bad = ld_offset[0];
      end
      3'b010: begin
        ld_ext = ld_rdata;
        ld_bad = (ld_offset != 2'b00);
      end
      3'b100: ld_ext = {{(XLEN-8){1'b0}}, ld_shifted[7:0]};
      3'b101: begin
        ld_ext = {{(XLEN-16){1'b0}}, ld_shifted[15:0]};
        ld_bad = ld_offset[0];
      end
      default: ld_bad = 1'b1;
    endcase
  end

  // Decode the scoreboard set and clear indices. x0 never becomes busy.
  // ld_was_busy reflects the state before this edge. It is used to flag
  // load returns that nobody was waiting for.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 1; i < NREG; i++) begin
      if (ld_issue && (ld_issue_rd == 5'(i))) set_mask[i] = 1'b1;
      if (ld_valid && (ld_rd == 5'(i)))       clr_mask[i] = 1'b1;
    end
    ld_was_busy = |(busy & clr_mask);
  end

  // Write-port arbitration and hold buffer.
  // Priority is: load return, then the held ALU result, then a new ALU result.
  // wb_rd and wb_data only change on a real write. When nothing is written
  // they keep their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      busy       <= '0;
      ld_err     <= 1'b0;
      hold_state <= HOLD_EMPTY;
      hold_rd    <= '0;
      hold_data  <= '0;
    end else begin
      // Set after clear, so a newer load to the same register stays pending.
      busy   <= (busy & ~clr_mask) | set_mask;
      wb_en  <= 1'b0;
      ld_err <= 1'b0;
      if (ld_valid) begin
        ld_err <= ld_bad || ((ld_rd != 5'd0) && !ld_was_busy);
        if (!ld_bad && (ld_rd != 5'd0)) begin
          wb_en   <= 1'b1;
          wb_rd   <= ld_rd;
          wb_data <= ld_ext;
        end
        if (alu_xfer) begin
          hold_state <= HOLD_FULL;
          hold_rd    <= alu_rd;
          hold_data  <= alu_data;
        end
      end else if (hold_state == HOLD_FULL) begin
        hold_state <= HOLD_EMPTY;
        if (hold_rd != 5'd0) begin
          wb_en   <= 1'b1;
          wb_rd   <= hold_rd;
          wb_data <= hold_data;
        end
      end else if (alu_xfer && (alu_rd != 5'd0)) begin
        wb_en   <= 1'b1;
        wb_rd   <= alu_rd;
        wb_data <= alu_data;
      end
    end
  end

`ifdef WB_FWD_EN
  // Bypass for the write that the regfile commits at the coming edge.
  always_comb begin
    fwd_hit    = 2'b00;
    fwd_hit[0] = wb_en && (wb_rd == fwd_rs1) && (wb_rd != 5'd0);
    fwd_hit[1] = wb_en && (wb_rd == fwd_rs2) && (wb_rd != 5'd0);
  end
  assign fwd_data = wb_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage.
// Directed scenarios check explicit expected constants. A randomized run is
// checked against a behavioural model that keeps the hold buffer as a queue,
// the scoreboard as a bit array, and does load extraction with arithmetic.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_issue = 1'b0;
  logic [4:0]  ld_issue_rd = '0;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_rd = '0;
  logic [2:0]  ld_funct3 = '0;
  logic [1:0]  ld_offset = '0;
  logic [31:0] ld_rdata = '0;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] busy;
  logic        ld_err;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_rs1 = '0;
  logic [4:0]  fwd_rs2 = '0;
  logic [1:0]  fwd_hit;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          m_wb_en;
  int          m_wb_rd;
  logic [31:0] m_wb_data;
  bit          m_ld_err;
  bit          m_busy [32];
  int          hq_rd [$];
  logic [31:0] hq_data [$];

  wb_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_offset(ld_offset),
    .ld_rdata(ld_rdata),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy), .ld_err(ld_err)
`ifdef WB_FWD_EN
    , .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  // Load value per the RV32I rules, using plain arithmetic.
  function automatic logic [31:0] load_value(input int f3, input int off,
                                             input logic [31:0] rdata, output bit bad);
    int unsigned b, h;
    logic [31:0] v;
    b = (rdata >> (8 * off)) & 32'hFF;
    h = (rdata >> (8 * off)) & 32'hFFFF;
    bad = 0;
    v = 0;
    case (f3)
      0: begin v = b; if (b >= 128) v = v - 32'd256; end
      1: begin v = h; if (h >= 32768) v = v - 32'd65536; bad = (off % 2) != 0; end
      2: begin v = rdata; bad = (off != 0); end
      4: v = b;
      5: begin v = h; bad = (off % 2) != 0; end
      default: bad = 1;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    m_wb_en = 0; m_wb_rd = 0; m_wb_data = 0; m_ld_err = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    hq_rd.delete(); hq_data.delete();
  endtask

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit ready, go, bad;
    logic [31:0] v;
    ready = (hq_rd.size() == 0);
    go = alu_valid && ready;
    m_wb_en = 0;
    m_ld_err = 0;
    if (ld_valid) begin
      v = load_value(int'(ld_funct3), int'(ld_offset), ld_rdata, bad);
      m_ld_err = bad || (ld_rd != 0 && !m_busy[ld_rd]);
      if (!bad && ld_rd != 0) begin m_wb_en = 1; m_wb_rd = ld_rd; m_wb_data = v; end
      if (go) begin hq_rd.push_back(int'(alu_rd)); hq_data.push_back(alu_data); end
    end else if (hq_rd.size() != 0) begin
      int r; logic [31:0] d;
      r = hq_rd.pop_front(); d = hq_data.pop_front();
      if (r != 0) begin m_wb_en = 1; m_wb_rd = r; m_wb_data = d; end
    end else if (go && alu_rd != 0) begin
      m_wb_en = 1; m_wb_rd = alu_rd; m_wb_data = alu_data;
    end
    if (ld_valid) m_busy[ld_rd] = 0;
    if (ld_issue && ld_issue_rd != 0) m_busy[ld_issue_rd] = 1;
  endtask

  task automatic set_idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0;
    ld_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_offset = 0; ld_rdata = 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    set_idle();
    rst = 1;
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    set_idle();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wb_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_en got %0b want 0", wb_en); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("[TB] FAIL reset_wb_rd got %0d want 0", wb_rd); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_wb_data got %h want 0", wb_data); end
    checks++; if (busy !== 32'd0) begin errors++; $display("[TB] FAIL reset_busy got %h want 0", busy); end
    checks++; if (ld_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ld_err got %0b want 0", ld_err); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_alu_ready got %0b want 1", alu_ready); end
    rst = 0;
  endtask

  task automatic test_alu_single();
    $display("[TB] test_alu_single");
    reset_dut();
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    step();
    set_idle();
    checks++; if (wb_en !== 1'b1) begin errors++; $display("[TB] FAIL alu_wb_en got %0b want 1", wb_en); end
    checks++; if (wb_rd !== 5'd5) begin errors++; $display("[TB] FAIL alu_wb_rd got %0d want 5", wb_rd); end
    checks++; if (wb_data !== 32'h00001234) begin errors++; $display("[TB] FAIL alu_wb_data got %h want 00001234", wb_data); end
    step();
    checks++; if (wb_en !== 1'b0) begin errors++; $display("[TB] FAIL alu_idle_wb_en got %0b want 0", wb_en); end
    checks++; if (wb_data !== 32'h00001234) begin errors++; $display("[TB] FAIL alu_hold_wb_data got %h want 00001234", wb_data); end
  endtask

  task automatic test_load_collision();
    $display("[TB] test_load_collision");
    reset_dut();
    ld_issue = 1; ld_issue_rd = 7;
    step();
    set_idle();
    checks++; if (busy[7] !== 1'b1) begin errors++; $display("[TB] FAIL coll_busy_set got %0b want 1", busy[7]); end
    ld_valid = 1; ld_rd = 7; ld_funct3 = 3'b000; ld_offset = 2; ld_rdata = 32'h00800000;
    alu_valid = 1; alu_rd = 3; alu_data = 32'hAA;
    step();
    set_idle();
    checks++; if (wb_en !== 1'b1 || wb_rd !== 5'd7) begin errors++; $display("[TB] FAIL coll_ld_write got en=%0b rd=%0d want en=1 rd=7", wb_en, wb_rd); end
    checks++; if (wb_data !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL coll_ld_data got %h want ffffff80", wb_data); end
    checks++; if (busy[7] !== 1'b0) begin errors++; $display("[TB] FAIL coll_busy_clr got %0b want 0", busy[7]); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("[TB] FAIL coll_ready_low got %0b want 0", alu_ready); end
    checks++; if (ld_err !== 1'b0) begin errors++; $display("[TB] FAIL coll_ld_err got %0b want 0", ld_err); end
    step();
    checks++; if (wb_en !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'hAA) begin errors++; $display("[TB] FAIL coll_hold_write got en=%0b rd=%0d data=%h want en=1 rd=3 data=000000aa", wb_en, wb_rd, wb_data); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL coll_ready_high got %0b want 1", alu_ready); end
  endtask

  task automatic test_half_loads();
    $display("[TB] test_half_loads");
    reset_dut();
    ld_issue = 1; ld_issue_rd = 10;
    step();
    set_idle();
    ld_valid = 1; ld_rd = 10; ld_funct3 = 3'b101; ld_offset = 2; ld_rdata = 32'hBEEF0000;
    ld_issue = 1; ld_issue_rd = 11;
    step();
    set_idle();
    checks++; if (wb_en !== 1'b1 || wb_rd !== 5'd10 || wb_data !== 32'h0000BEEF) begin errors++; $display("[TB] FAIL lhu_write got en=%0b rd=%0d data=%h want en=1 rd=10 data=0000beef", wb_en, wb_rd, wb_data); end
    ld_valid = 1; ld_rd = 11; ld_funct3 = 3'b001; ld_offset = 1; ld_rdata = 32'h12345678;
    step();
    set_idle();
    checks++; if (wb_en !== 1'b0) begin errors++; $display("[TB] FAIL lh_mis_wb_en got %0b want 0", wb_en); end
    checks++; if (ld_err !== 1'b1) begin errors++; $display("[TB] FAIL lh_mis_ld_err got %0b want 1", ld_err); end
    checks++; if (busy[11] !== 1'b0) begin errors++; $display("[TB] FAIL lh_mis_busy got %0b want 0", busy[11]); end
    checks++; if (wb_rd !== 5'd10 || wb_data !== 32'h0000BEEF) begin errors++; $display("[TB] FAIL lh_mis_hold got rd=%0d data=%h want rd=10 data=0000beef", wb_rd, wb_data); end
    step();
    checks++; if (ld_err !== 1'b0) begin errors++; $display("[TB] FAIL lh_err_pulse got %0b want 0", ld_err); end
  endtask

  task automatic test_same_cycle_issue();
    $display("[TB] test_same_cycle_issue");
    reset_dut();
    ld_issue = 1; ld_issue_rd = 9;
    step();
    set_idle();
    ld_issue = 1; ld_issue_rd = 9;
    ld_valid = 1; ld_rd = 9; ld_funct3 = 3'b010; ld_offset = 0; ld_rdata = 32'hCAFEF00D;
    step();
    set_idle();
    checks++; if (wb_en !== 1'b1 || wb_rd !== 5'd9 || wb_data !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL same_write got en=%0b rd=%0d data=%h want en=1 rd=9 data=cafef00d", wb_en, wb_rd, wb_data); end
    checks++; if (busy[9] !== 1'b1) begin errors++; $display("[TB] FAIL same_busy got %0b want 1", busy[9]); end
  endtask

  task automatic test_x0();
    $display("[TB] test_x0");
    reset_dut();
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF;
    ld_issue = 1; ld_issue_rd = 0;
    step();
    set_idle();
    checks++; if (wb_en !== 1'b0) begin errors++; $display("[TB] FAIL x0_wb_en got %0b want 0", wb_en); end
    checks++; if (busy !== 32'd0) begin errors++; $display("[TB] FAIL x0_busy got %h want 0", busy); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("[TB] FAIL x0_wb_data got %h want 0", wb_data); end
  endtask

  task automatic test_reset_while_full();
    $display("[TB] test_reset_while_full");
    reset_dut();
    ld_issue = 1; ld_issue_rd = 4;
    step();
    set_idle();
    ld_valid = 1; ld_rd = 4; ld_funct3 = 3'b010; ld_rdata = 32'h11112222;
    alu_valid = 1; alu_rd = 6; alu_data = 32'h5555AAAA;
    ld_issue = 1; ld_issue_rd = 12;
    step();
    set_idle();
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstfull_ready_pre got %0b want 0", alu_ready); end
    #1;
    rst = 1;
    model_reset();
    #1;
    checks++; if (wb_en !== 1'b0) begin errors++; $display("[TB] FAIL rstfull_wb_en got %0b want 0", wb_en); end
    checks++; if (busy !== 32'd0) begin errors++; $display("[TB] FAIL rstfull_busy got %h want 0", busy); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstfull_ready got %0b want 1", alu_ready); end
    @(posedge clk); #1;
    rst = 0;
    step();
    checks++; if (wb_en !== 1'b0) begin errors++; $display("[TB] FAIL rstfull_no_held_write got %0b want 0", wb_en); end
    checks++; if (wb_rd !== 5'd0 || wb_data !== 32'd0) begin errors++; $display("[TB] FAIL rstfull_port got rd=%0d data=%h want rd=0 data=0", wb_rd, wb_data); end
  endtask

  task automatic test_random();
    logic [31:0] exp_busy;
    $display("[TB] test_random");
    reset_dut();
    for (int n = 0; n < 400; n++) begin
      alu_valid   = ($urandom_range(0, 9) < 6);
      alu_rd      = 5'($urandom_range(0, 31));
      alu_data    = $urandom;
      ld_issue    = ($urandom_range(0, 9) < 3);
      ld_issue_rd = 5'($urandom_range(0, 31));
      ld_valid    = ($urandom_range(0, 9) < 4);
      ld_rd       = 5'($urandom_range(1, 31));
      ld_funct3   = 3'($urandom_range(0, 7));
      ld_offset   = 2'($urandom_range(0, 3));
      ld_rdata    = $urandom;
      step();
      exp_busy = model_busy_vec();
      checks++; if (wb_en !== m_wb_en) begin errors++; $display("[TB] FAIL rand_wb_en cycle %0d got %0b want %0b", n, wb_en, m_wb_en); end
      checks++; if (wb_rd !== 5'(m_wb_rd) || wb_data !== m_wb_data) begin errors++; $display("[TB] FAIL rand_port cycle %0d got rd=%0d data=%h want rd=%0d data=%h", n, wb_rd, wb_data, m_wb_rd, m_wb_data); end
      checks++; if (ld_err !== m_ld_err) begin errors++; $display("[TB] FAIL rand_ld_err cycle %0d got %0b want %0b", n, ld_err, m_ld_err); end
      checks++; if (busy !== exp_busy) begin errors++; $display("[TB] FAIL rand_busy cycle %0d got %h want %h", n, busy, exp_busy); end
      checks++; if (alu_ready !== (hq_rd.size() == 0)) begin errors++; $display("[TB] FAIL rand_alu_ready cycle %0d got %0b want %0b", n, alu_ready, hq_rd.size() == 0); end
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_load_collision();
    test_half_loads();
    test_same_cycle_issue();
    test_x0();
    test_reset_while_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
